// File: rtl/fios_pkg.sv
// Shared definitions for the FIOS Montgomery datapath blocks.
package fios_pkg;

    // Result collector control states.
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } collector_state_t;

    // Default operand length in words and the matching counter width.
    localparam int unsigned DEFAULT_S = 8;
    localparam int unsigned CNT_W     = $clog2(DEFAULT_S + 1);

    // Counter width able to hold the values 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fios_word_sub.sv
// One-word subtract-with-borrow slice: diff = a - b - borrow_in.
module fios_word_sub #(
    parameter int unsigned WORD_WIDTH = 17
) (
    input  logic [WORD_WIDTH-1:0] a,
    input  logic [WORD_WIDTH-1:0] b,
    input  logic                  borrow_in,
    output logic [WORD_WIDTH-1:0] diff,
    output logic                  borrow_out
);

    logic [WORD_WIDTH:0] full;

    // Extended-width subtract; the extra MSB is set exactly when the result is negative.
    always_comb begin
        full       = {1'b0, a} - {1'b0, b} - {{WORD_WIDTH{1'b0}}, borrow_in};
        diff       = full[WORD_WIDTH-1:0];
        borrow_out = full[WORD_WIDTH];
    end

endmodule

// File: rtl/fios_result_collector.sv
// Word-serial collector for the FIOS multiplier result stream with
// final conditional subtraction of the modulus and a one-entry output buffer.
module fios_result_collector #(
    parameter int unsigned WORD_WIDTH = 17,
    parameter int unsigned s          = 8
) (
    input  logic                       clock_i,
    input  logic                       reset_n_i,
    input  logic                       res_start_i,
    input  logic [WORD_WIDTH-1:0]      res_word_i,
    input  logic [s*WORD_WIDTH-1:0]    p_i,
    output logic [s*WORD_WIDTH-1:0]    result_o,
    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output logic                       busy_o,
    output logic                       overrun_o
);

    import fios_pkg::*;

    localparam int unsigned     CW   = cnt_width(s);
    localparam logic [CW-1:0]   LAST = CW'(s - 1);

    collector_state_t          state;
    logic [CW-1:0]             cnt;
    logic [CW-1:0]             word_idx;
    logic                      borrow_q;
    logic                      borrow_in;
    logic                      borrow_out;
    logic                      accept;
    logic                      complete;
    logic [WORD_WIDTH-1:0]     p_word;
    logic [WORD_WIDTH-1:0]     diff;
    logic [s*WORD_WIDTH-1:0]   raw_next;
    logic [s*WORD_WIDTH-1:0]   sub_next;

    // Word acceptance, word index, incoming borrow and modulus word selection.
    always_comb begin
        accept    = res_start_i || (state == COLLECT);
        word_idx  = res_start_i ? '0 : cnt;
        borrow_in = res_start_i ? 1'b0 : borrow_q;
        complete  = accept && (word_idx == LAST);
        p_word    = '0;
        for (int unsigned i = 0; i < s; i++) begin
            if (word_idx == CW'(i)) begin
                p_word = p_i[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    fios_word_sub #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_word_sub (
        .a          (res_word_i),
        .b          (p_word),
        .borrow_in  (borrow_in),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    // The s-word raw/sub shift registers are formed by the incoming word on top of
    // s-1 stored words; the full s-word value is available combinationally on the
    // final word, so only the history needs flops.
    if (s > 1) begin : g_hist
        logic [(s-1)*WORD_WIDTH-1:0] raw_hist;
        logic [(s-1)*WORD_WIDTH-1:0] sub_hist;

        assign raw_next = {res_word_i, raw_hist};
        assign sub_next = {diff, sub_hist};

        // Shift history; a restart needs no flush since s fresh words overwrite it.
        always_ff @(posedge clock_i) begin
            if (accept) begin
                raw_hist <= raw_next[s*WORD_WIDTH-1:WORD_WIDTH];
                sub_hist <= sub_next[s*WORD_WIDTH-1:WORD_WIDTH];
            end
        end
    end else begin : g_single
        assign raw_next = res_word_i;
        assign sub_next = diff;
    end

    // Collection FSM, word counter, running borrow and busy flag.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state    <= IDLE;
            cnt      <= '0;
            borrow_q <= 1'b0;
            busy_o   <= 1'b0;
        end else if (accept) begin
            borrow_q <= borrow_out;
            if (complete) begin
                state  <= IDLE;
                cnt    <= '0;
                busy_o <= 1'b0;
            end else begin
                state  <= COLLECT;
                cnt    <= word_idx + 1'b1;
                busy_o <= 1'b1;
            end
        end
    end

    // Output buffer with valid/ready handshake and sticky overrun flag.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            result_o       <= '0;
            result_valid_o <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            if ((state == COLLECT) && res_start_i) begin
                overrun_o <= 1'b1;
            end
            if (complete) begin
                if (!result_valid_o || result_ready_i) begin
                    result_o       <= borrow_out ? raw_next : sub_next;
                    result_valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (result_valid_o && result_ready_i) begin
                result_valid_o <= 1'b0;
            end
        end
    end

endmodule
